coin_collision_tracker: RTL and testbench

//  Pixel-rate collision stage feeding the coin bitmap. Detects pacman/coin pixel overlap,

---
 rtl/coin_pkg.sv | 46 ++++
 rtl/bcd_score_counter.sv | 24 ++
 rtl/coin_collision_tracker.sv | 99 +++++++++
 tb/tb_coin_collision_tracker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types, defaults and BCD helpers for the coin collision tracker.
package coin_pkg;

  localparam int TOTAL_COINS_DFLT = 233;
  localparam int COIN_POINTS_DFLT = 10;

  typedef struct packed {
    logic [3:0] row;
    logic [4:0] col;
  } cell_t;

  typedef enum logic {
    PLAY    = 1'b0,
    CLEARED = 1'b1
  } coin_state_t;

  typedef logic [15:0] bcd4_t;

  // Binary 0..99 to two BCD digits.
  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Four-digit BCD add of a two-digit addend; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input bcd4_t a, input logic [7:0] b);
    logic [15:0] b_ext;
    logic [15:0] s;
    logic        c;
    logic [4:0]  d;
    b_ext = {8'h00, b};
    s     = 16'h0000;
    c     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b_ext[4*i +: 4]} + {4'b0000, c};
      if (d > 5'd9) begin
        s[4*i +: 4] = 4'(d - 5'd10);
        c           = 1'b1;
      end else begin
        s[4*i +: 4] = d[3:0];
        c           = 1'b0;
      end
    end
    return {c, s};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score accumulator that pins at 9999 instead of wrapping.
module bcd_score_counter
  import coin_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       add_en,
  input  logic [7:0] addend,
  output bcd4_t      score
);

  logic [16:0] sum;

  assign sum = bcd_add(score, addend);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score <= 16'h0000;
    end else if (add_en) begin
      score <= sum[16] ? 16'h9999 : sum[15:0];
    end
  end

endmodule

// File: rtl/coin_collision_tracker.sv
// Pacman/coin overlap detection, per-coin dedup, coin and score counting, level-clear flag.
module coin_collision_tracker
  import coin_pkg::*;
#(
  parameter int TOTAL_COINS = TOTAL_COINS_DFLT,
  parameter int COIN_POINTS = COIN_POINTS_DFLT
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       newLevel,
  input  logic [3:0] cellRow,
  input  logic [4:0] cellCol,
  input  logic       pacmanDrawingRequest,
  input  logic       coinDrawingRequest,
  output logic       collision_pc,
  output logic       coinEaten,
  output bcd4_t      score,
  output logic [7:0] coinsLeft,
  output logic       levelCleared
);

  localparam logic [7:0] COINS_INIT = 8'(TOTAL_COINS);
  localparam logic [7:0] POINTS_BCD = to_bcd2(COIN_POINTS);

  coin_state_t state;
  cell_t       cell_d;
  cell_t       last_cell;
  logic        last_valid;
  logic        hit;
  logic        new_coin;
  logic        count_en;

  assign hit          = pacmanDrawingRequest & coinDrawingRequest & (state == PLAY);
  assign collision_pc = hit;
  assign new_coin     = hit & ~(last_valid & (cell_d == last_cell));
  assign count_en     = new_coin & ~newLevel & (coinsLeft != 8'd0);

  // Cell offsets lead the coin drawing request by one pixel; newCoin beats startOfFrame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cell_d     <= '0;
      last_cell  <= '0;
      last_valid <= 1'b0;
    end else begin
      cell_d <= {cellRow, cellCol};
      if (newLevel) begin
        last_valid <= 1'b0;
      end else if (new_coin) begin
        last_cell  <= cell_d;
        last_valid <= 1'b1;
      end else if (startOfFrame) begin
        last_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= PLAY;
      coinsLeft    <= COINS_INIT;
      coinEaten    <= 1'b0;
      levelCleared <= 1'b0;
    end else begin
      coinEaten <= count_en;
      if (newLevel) begin
        coinsLeft    <= COINS_INIT;
        state        <= PLAY;
        levelCleared <= 1'b0;
      end else begin
        if (count_en) begin
          coinsLeft <= coinsLeft - 8'd1;
        end
        case (state)
          PLAY: begin
            if (count_en && (coinsLeft == 8'd1)) begin
              state        <= CLEARED;
              levelCleared <= 1'b1;
            end
          end
          CLEARED: levelCleared <= 1'b1;
          default: begin
            state        <= PLAY;
            levelCleared <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_score_counter u_score (
    .clk    (clk),
    .resetN (resetN),
    .add_en (count_en),
    .addend (POINTS_BCD),
    .score  (score)
  );

endmodule

// File: tb/tb_coin_collision_tracker.sv
// Scoreboard bench: dut_a uses the default maze, dut_b a 2-coin maze worth 99 points per coin.
module tb_coin_collision_tracker;

  typedef struct packed {
    logic [15:0] s;
    logic [7:0]  l;
  } exp_t;

  logic        clk    = 1'b0;
  logic        resetN = 1'b0;
  logic [1:0]  sof    = 2'b00;
  logic [1:0]  nl     = 2'b00;
  logic [1:0]  pdr    = 2'b00;
  logic [1:0]  cdr    = 2'b00;
  logic [3:0]  row    [2];
  logic [4:0]  col    [2];
  logic        cpc    [2];
  logic        ce     [2];
  logic        lc     [2];
  logic [15:0] score  [2];
  logic [7:0]  left   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cpc_cnt [2] = '{0, 0};
  int   nb;
  int   ll;
  int   pts;

  always #5 clk = ~clk;

  coin_collision_tracker dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof[0]), .newLevel(nl[0]),
    .cellRow(row[0]), .cellCol(col[0]),
    .pacmanDrawingRequest(pdr[0]), .coinDrawingRequest(cdr[0]),
    .collision_pc(cpc[0]), .coinEaten(ce[0]), .score(score[0]),
    .coinsLeft(left[0]), .levelCleared(lc[0])
  );

  coin_collision_tracker #(.TOTAL_COINS(2), .COIN_POINTS(99)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof[1]), .newLevel(nl[1]),
    .cellRow(row[1]), .cellCol(col[1]),
    .pacmanDrawingRequest(pdr[1]), .coinDrawingRequest(cdr[1]),
    .collision_pc(cpc[1]), .coinEaten(ce[1]), .score(score[1]),
    .coinsLeft(left[1]), .levelCleared(lc[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [15:0] es, input logic [7:0] el);
    exp_t e;
    e.s = es;
    e.l = el;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop_check(input int d);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : q1.size();
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL pulse_dut%0d: coinEaten with no coin expected, score=%0h left=%0d", d, score[d], left[d]);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("score_dut%0d", d), 32'(score[d]), 32'(e.s));
      chk($sformatf("left_dut%0d", d), 32'(left[d]), 32'(e.l));
    end
  endtask

  function automatic logic [15:0] bcd16(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Monitor: compares every coinEaten pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (resetN) begin
      for (int d = 0; d < 2; d++) begin
        if (cpc[d]) cpc_cnt[d]++;
        if (ce[d]) pop_check(d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [3:0] r, input logic [4:0] c,
                       input logic req, input logic s, input logic n);
    row[d] = r;
    col[d] = c;
    pdr[d] = req;
    cdr[d] = req;
    sof[d] = s;
    nl[d]  = n;
    step();
  endtask

  task automatic burst(input int d, input logic [3:0] r, input logic [4:0] c,
                       input int n, input logic s_first);
    drive(d, r, c, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) drive(d, r, c, 1'b1, (i == 0) && s_first, 1'b0);
    drive(d, r, c, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      row[d] = 4'd0;
      col[d] = 5'd0;
    end
    step();
    step();
    chk("rst_score_a", 32'(score[0]), 32'h0000);
    chk("rst_left_a", 32'(left[0]), 32'd233);
    chk("rst_eaten_a", 32'(ce[0]), 32'd0);
    chk("rst_cleared_a", 32'(lc[0]), 32'd0);
    chk("rst_cpc_a", 32'(cpc[0]), 32'd0);
    chk("rst_left_b", 32'(left[1]), 32'd2);
    resetN = 1'b1;
    step();

    // 11-pixel overlap in one cell: one count.
    push(0, 16'h0010, 8'd232);
    burst(0, 4'd3, 5'd5, 11, 1'b0);
    step();
    chk("t1_cpc_cycles", 32'(cpc_cnt[0]), 32'd11);
    chk("t1_score", 32'(score[0]), 32'h0010);
    chk("t1_drained", 32'(q0.size()), 32'd0);

    // New frame, two neighbouring coins, then a repeat of the second.
    drive(0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    push(0, 16'h0020, 8'd231);
    burst(0, 4'd3, 5'd5, 4, 1'b0);
    push(0, 16'h0030, 8'd230);
    burst(0, 4'd3, 5'd6, 4, 1'b0);
    burst(0, 4'd3, 5'd6, 3, 1'b0);
    step();
    chk("t2_left", 32'(left[0]), 32'd230);
    chk("t2_drained", 32'(q0.size()), 32'd0);

    // startOfFrame clears dedup; startOfFrame coinciding with a new coin keeps it.
    drive(0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    push(0, 16'h0040, 8'd229);
    burst(0, 4'd2, 5'd2, 2, 1'b0);
    drive(0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    push(0, 16'h0050, 8'd228);
    burst(0, 4'd2, 5'd2, 2, 1'b0);
    push(0, 16'h0060, 8'd227);
    burst(0, 4'd2, 5'd3, 2, 1'b1);
    burst(0, 4'd2, 5'd3, 2, 1'b0);
    step();
    chk("t3_score", 32'(score[0]), 32'h0060);
    chk("t3_drained", 32'(q0.size()), 32'd0);

    // Two-coin maze: clear, blocked overlaps, newLevel.
    push(1, 16'h0099, 8'd1);
    burst(1, 4'd1, 5'd0, 3, 1'b0);
    push(1, 16'h0198, 8'd0);
    burst(1, 4'd1, 5'd1, 3, 1'b0);
    chk("t4_cleared", 32'(lc[1]), 32'd1);
    chk("t4_left0", 32'(left[1]), 32'd0);
    chk("t4_cpc_cycles", 32'(cpc_cnt[1]), 32'd4);
    burst(1, 4'd1, 5'd2, 3, 1'b0);
    chk("t4_blocked_cpc", 32'(cpc_cnt[1]), 32'd4);
    chk("t4_blocked_score", 32'(score[1]), 32'h0198);
    drive(1, 4'd1, 5'd2, 1'b0, 1'b0, 1'b1);
    chk("t4_nl_left", 32'(left[1]), 32'd2);
    chk("t4_nl_cleared", 32'(lc[1]), 32'd0);
    chk("t4_nl_score", 32'(score[1]), 32'h0198);
    drive(1, 4'd1, 5'd3, 1'b0, 1'b0, 1'b0);
    drive(1, 4'd1, 5'd3, 1'b1, 1'b0, 1'b1);
    drive(1, 4'd1, 5'd3, 1'b0, 1'b0, 1'b0);
    step();
    chk("t4_nl_hit_cpc", 32'(cpc_cnt[1]), 32'd5);
    chk("t4_nl_hit_left", 32'(left[1]), 32'd2);
    chk("t4_drained", 32'(q1.size()), 32'd0);

    // Run the score up to and past 9999.
    nb = 2;
    ll = 2;
    while (nb < 102) begin
      if (ll == 0) begin
        drive(1, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        ll = 2;
      end
      nb++;
      ll--;
      pts = nb * 99;
      if (pts > 9999) pts = 9999;
      push(1, bcd16(pts), 8'(ll));
      burst(1, 4'd5, 5'(nb % 2), 1, 1'b0);
    end
    step();
    chk("t5_saturated", 32'(score[1]), 32'h9999);
    chk("t5_drained", 32'(q1.size()), 32'd0);

    // Async reset in the middle of an overlap burst.
    push(0, 16'h0070, 8'd226);
    drive(0, 4'd4, 5'd4, 1'b0, 1'b0, 1'b0);
    drive(0, 4'd4, 5'd4, 1'b1, 1'b0, 1'b0);
    drive(0, 4'd4, 5'd4, 1'b1, 1'b0, 1'b0);
    resetN = 1'b0;
    pdr[0] = 1'b0;
    cdr[0] = 1'b0;
    #2;
    chk("t6_score_a", 32'(score[0]), 32'h0000);
    chk("t6_left_a", 32'(left[0]), 32'd233);
    chk("t6_eaten_a", 32'(ce[0]), 32'd0);
    chk("t6_cpc_a", 32'(cpc[0]), 32'd0);
    chk("t6_score_b", 32'(score[1]), 32'h0000);
    chk("t6_left_b", 32'(left[1]), 32'd2);
    chk("t6_cleared_b", 32'(lc[1]), 32'd0);
    chk("t6_drained", 32'(q0.size()), 32'd0);
    step();
    resetN = 1'b1;
    step();
    push(0, 16'h0010, 8'd232);
    burst(0, 4'd4, 5'd4, 3, 1'b0);
    step();
    step();
    chk("t6_resume_drained", 32'(q0.size()), 32'd0);
    chk("t6_resume_score", 32'(score[0]), 32'h0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
